// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared constants for the systolic array sequencer: default sizes,
// wait-counter geometry and the 2-bit FSM state encodings.
package systolic_seq_ctrl_pkg;

    localparam int WORDLENGTH_DEF   = 16;
    localparam int NUM_PE_DEF       = 8;
    localparam int IDX_W_DEF        = 3;
    localparam int MULT_TIMEOUT_DEF = 31;

    // Wait counter cycles during which pe_busy is ignored after a start pulse
    localparam int BLANK_CYCLES = 2;
    localparam int CNT_W        = 5;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LAUNCH    = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_CAPTURE   = 2'd3;

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// Handshake and PE-array bus of the systolic sequencer.
// master: sample source / PE array side, slave: the controller.
interface systolic_seq_ctrl_if #(
    parameter int WORDLENGTH = 16,
    parameter int NUM_PE     = 8,
    parameter int IDX_W      = 3
);
    logic                  in_valid;
    logic [WORDLENGTH-1:0] in_word;
    logic                  in_ready;
    logic [NUM_PE-1:0]     pe_busy;
    logic [WORDLENGTH-1:0] pe_word;
    logic                  mult_start;
    logic [IDX_W-1:0]      word_index;
    logic [NUM_PE-1:0]     acc_clear;
    logic                  acc_capture;
    logic [NUM_PE-1:0]     pe_out_valid;
    logic                  timeout_err;

    modport master (
        output in_valid, in_word, pe_busy,
        input  in_ready, pe_word, mult_start, word_index, acc_clear,
               acc_capture, pe_out_valid, timeout_err
    );

    modport slave (
        input  in_valid, in_word, pe_busy,
        output in_ready, pe_word, mult_start, word_index, acc_clear,
               acc_capture, pe_out_valid, timeout_err
    );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Central sequencer for the 8-PE systolic interpolation array: accepts a
// sample, broadcasts it, fires one shared multiplier start, waits for all
// PE multipliers and strobes the accumulator capture.
module systolic_seq_ctrl
    import systolic_seq_ctrl_pkg::*;
#(
    parameter int WORDLENGTH   = WORDLENGTH_DEF,
    parameter int NUM_PE       = NUM_PE_DEF,
    parameter int IDX_W        = IDX_W_DEF,
    parameter int MULT_TIMEOUT = MULT_TIMEOUT_DEF
) (
    input logic              clk30x,
    input logic              reset,
    systolic_seq_ctrl_if.slave bus
);

    // PE p takes its first term while word_index == p
    function automatic logic [NUM_PE-1:0] first_term_dec(input logic [IDX_W-1:0] idx);
        logic [NUM_PE-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // PE p completes its sum when word_index == (p + NUM_PE - 1) mod NUM_PE
    function automatic logic [NUM_PE-1:0] last_term_dec(input logic [IDX_W-1:0] idx);
        logic [NUM_PE-1:0] v;
        logic [IDX_W-1:0]  nxt;
        nxt    = idx + 1'b1;
        v      = '0;
        v[nxt] = 1'b1;
        return v;
    endfunction

    logic [1:0]            state_q, state_d;
    logic [WORDLENGTH-1:0] pe_word_q, pe_word_d;
    logic [IDX_W-1:0]      word_index_q, word_index_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  in_ready_q, in_ready_d;

    // Next-state, sample capture, wait counter and index advance
    always_comb begin
        state_d       = state_q;
        pe_word_d     = pe_word_q;
        word_index_d  = word_index_q;
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_ready_q && bus.in_valid) begin
                    pe_word_d = bus.in_word;
                    state_d   = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                cnt_d   = '0;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // Done wins over a simultaneous timeout
                if (cnt_q >= CNT_W'(BLANK_CYCLES) && bus.pe_busy == '0) begin
                    state_d = ST_CAPTURE;
                end else if (cnt_q == CNT_W'(MULT_TIMEOUT)) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CAPTURE: begin
                word_index_d = word_index_q + 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered from the next state so in_ready stays low through reset
        // and rises one cycle after it is released
        in_ready_d = (state_d == ST_IDLE);
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk30x) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pe_word_q     <= '0;
            word_index_q  <= '0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
            in_ready_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pe_word_q     <= pe_word_d;
            word_index_q  <= word_index_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
            in_ready_q    <= in_ready_d;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        bus.in_ready     = in_ready_q;
        bus.pe_word      = pe_word_q;
        bus.word_index   = word_index_q;
        bus.mult_start   = (state_q == ST_LAUNCH);
        bus.acc_capture  = (state_q == ST_CAPTURE);
        bus.acc_clear    = first_term_dec(word_index_q);
        bus.pe_out_valid = (state_q == ST_CAPTURE) ? last_term_dec(word_index_q) : '0;
        bus.timeout_err  = timeout_err_q;
    end

endmodule
